// File: rtl/seq_divider16x8.sv
// Iterative restoring divider: NW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; results held from the done cycle until the next acceptance.
module seq_divider16x8 #(
  parameter int NW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          dbz
);

  localparam int CW = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [NW-1:0] n_reg;   // dividend shifts out of the MSB, quotient bits shift into the LSB
  logic [DW-1:0] d_reg;
  logic [DW-1:0] r_reg;
  logic [CW-1:0] count;

  logic [DW:0]   r_shift;
  logic [DW:0]   r_diff;
  logic          q_bit;
  logic [DW-1:0] r_step;

  // The borrow out of the trial subtraction decides the quotient bit.
  always_comb begin
    r_shift = {r_reg, n_reg[NW-1]};
    r_diff  = r_shift - {1'b0, d_reg};
    q_bit   = ~r_diff[DW];
    r_step  = q_bit ? r_diff[DW-1:0] : r_shift[DW-1:0];
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= CW'(NW);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[DW-1:0];
              dbz       <= 1'b1;
            end
          end
        end
        RUN: begin
          n_reg <= {n_reg[NW-2:0], q_bit};
          r_reg <= r_step;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            quotient  <= {n_reg[NW-2:0], q_bit};
            remainder <= r_step;
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider16x8.sv
// Self-checking bench for seq_divider16x8: directed cases plus a random sweep
// against an arithmetic reference model.
module tb_seq_divider16x8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] prev_q;
  logic [7:0]  prev_r;
  logic        prev_z;

  seq_divider16x8 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r, output logic z);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = a / b;
      r = 8'(a % b);
      z = 1'b0;
    end
  endfunction

  // Called at posedge+1 of cycle 0; returns at posedge+1 of the cycle after done.
  task automatic do_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input int glitch_cycle, input bit glitch_done);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          cyc;
    bit          seen;
    model(a, b, eq, er, ez);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (cyc == glitch_cycle) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (cyc == 1) begin
        check($sformatf("%s.busy_c1", tag), busy, 1);
        if (b != 8'd0) check($sformatf("%s.held_q", tag), quotient, prev_q);
      end
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check($sformatf("%s.latency", tag), cyc, (b == 8'd0) ? 1 : 17);
    check($sformatf("%s.busy_done", tag), busy, 1);
    check($sformatf("%s.q", tag), quotient, eq);
    check($sformatf("%s.r", tag), remainder, er);
    check($sformatf("%s.dbz", tag), dbz, ez);
    prev_q = eq;
    prev_r = er;
    prev_z = ez;
    if (glitch_done) begin
      start    = 1'b1;
      dividend = 16'd50;
      divisor  = 8'd5;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("%s.done_low_after", tag), done, 0);
    check($sformatf("%s.idle_after", tag), busy, 0);
    check($sformatf("%s.q_held_after", tag), quotient, eq);
  endtask

  initial begin
    int pulses;
    logic [15:0] ra;
    logic [7:0]  rb;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    prev_q   = '0;
    prev_r   = '0;
    prev_z   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.q", quotient, 0);
    check("reset.r", remainder, 0);
    check("reset.dbz", dbz, 0);
    @(posedge clk); #1;

    do_div("t1_1000_7", 16'd1000, 8'd7, -1, 0);
    do_div("t2_65535_1", 16'd65535, 8'd1, -1, 0);
    do_div("t2_65535_255", 16'd65535, 8'd255, -1, 0);
    do_div("t3_5_10", 16'd5, 8'd10, -1, 0);
    do_div("t3_0_3", 16'd0, 8'd3, -1, 0);
    do_div("t4_dbz", 16'h1234, 8'd0, -1, 0);
    do_div("t4_100_9", 16'd100, 8'd9, -1, 0);
    do_div("t5_ignored", 16'd1000, 8'd7, 5, 1);
    do_div("t5_b2b", 16'd200, 8'd3, -1, 0);

    // Reset in the middle of a run aborts it silently.
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6.busy", busy, 0);
    check("t6.done", done, 0);
    check("t6.q", quotient, 0);
    check("t6.r", remainder, 0);
    check("t6.dbz", dbz, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("t6.no_done", pulses, 0);
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;
    @(posedge clk); #1;
    do_div("t6_200_3", 16'd200, 8'd3, -1, 0);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'($urandom_range(0, 255));
        default: ra = 16'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) rb = 8'd0;
      else                            rb = 8'($urandom_range(1, 255));
      do_div($sformatf("rnd%0d", i), ra, rb, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
